// File: rtl/stepper_move_controller.sv
// Stepper move sequencer: accepts a step-count/direction command, honours DIR setup time,
// and emits fixed-width STEP pulses paced by rising edges of an external rate square wave.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   SETUP | dir_out settling before the first step
//   RUN   | waiting for a rate edge to issue a step
//   HIGH  | step pulse in progress
//   DONE  | one-cycle done pulse, back to IDLE next
module stepper_move_controller #(
    parameter int POS_W            = 32,
    parameter int DIR_SETUP_CYCLES = 4,
    parameter int STEP_HIGH_CYCLES = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             rate_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position,
    output logic [POS_W-1:0] steps_remaining,
    output logic             rate_overrun
);

    localparam int CNT_MAX = (DIR_SETUP_CYCLES > STEP_HIGH_CYCLES) ? DIR_SETUP_CYCLES
                                                                   : STEP_HIGH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(STEP_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rate_prev;
    logic               rise;
    logic               abort_pend, abort_pend_nxt;
    logic               step_nxt, dir_nxt, done_nxt, ovr_nxt;
    logic [POS_W-1:0]   pos_nxt, rem_nxt;

    assign rise      = rate_in & ~rate_prev;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state           <= IDLE;
            cnt             <= '0;
            rate_prev       <= 1'b0;
            abort_pend      <= 1'b0;
            step_out        <= 1'b0;
            dir_out         <= 1'b0;
            done            <= 1'b0;
            position        <= '0;
            steps_remaining <= '0;
            rate_overrun    <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            rate_prev       <= rate_in;
            abort_pend      <= abort_pend_nxt;
            step_out        <= step_nxt;
            dir_out         <= dir_nxt;
            done            <= done_nxt;
            position        <= pos_nxt;
            steps_remaining <= rem_nxt;
            rate_overrun    <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        abort_pend_nxt = abort_pend;
        step_nxt       = step_out;
        dir_nxt        = dir_out;
        done_nxt       = 1'b0;
        pos_nxt        = position;
        rem_nxt        = steps_remaining;
        ovr_nxt        = rate_overrun;

        case (state)
            IDLE: begin
                abort_pend_nxt = 1'b0;
                if (cmd_valid) begin
                    ovr_nxt = 1'b0;
                    rem_nxt = cmd_steps;
                    if (cmd_steps != '0) begin
                        dir_nxt   = cmd_dir;
                        cnt_nxt   = SETUP_LOAD;
                        state_nxt = SETUP;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RUN: begin
                // abort takes priority over a coincident rate edge
                if (abort) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (rise && (steps_remaining != '0)) begin
                    step_nxt  = 1'b1;
                    rem_nxt   = steps_remaining - POS_W'(1);
                    pos_nxt   = dir_out ? position + POS_W'(1) : position - POS_W'(1);
                    cnt_nxt   = HIGH_LOAD;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (rise) begin
                    ovr_nxt = 1'b1;
                end
                if (abort) begin
                    abort_pend_nxt = 1'b1;
                end
                if (cnt == '0) begin
                    step_nxt = 1'b0;
                    if ((steps_remaining == '0) || abort_pend || abort) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                abort_pend_nxt = 1'b0;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stepper_move_controller.sv
// Bench for stepper_move_controller: directed and randomized moves, each checked against
// per-move expectations (pulse count/width/spacing, position, remaining steps, overrun).
module tb_stepper_move_controller;

    localparam int POS_W = 32;
    localparam int DS    = 4;
    localparam int SH    = 8;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             rate_in = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic             abort = 1'b0;
    logic             step_out;
    logic             dir_out;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;
    logic [POS_W-1:0] steps_remaining;
    logic             rate_overrun;

    int               n_checks = 0;
    int               n_errors = 0;
    int               rate_period = 40;
    int               ph = 0;
    logic [POS_W-1:0] pos_model = '0;
    logic             dir_model = 1'b0;

    stepper_move_controller #(
        .POS_W           (POS_W),
        .DIR_SETUP_CYCLES(DS),
        .STEP_HIGH_CYCLES(SH)
    ) dut (
        .clk            (clk),
        .resetb         (resetb),
        .rate_in        (rate_in),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_steps      (cmd_steps),
        .cmd_dir        (cmd_dir),
        .abort          (abort),
        .step_out       (step_out),
        .dir_out        (dir_out),
        .busy           (busy),
        .done           (done),
        .position       (position),
        .steps_remaining(steps_remaining),
        .rate_overrun   (rate_overrun)
    );

    always #5 clk = ~clk;

    // free-running rate square wave, one rising edge per rate_period cycles
    initial begin
        forever begin
            @(negedge clk);
            if (ph >= rate_period) ph = 0;
            rate_in = (ph < rate_period / 2);
            ph++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // abort_mode: 0 none, -1 during direction setup, k>0 during the k-th pulse
    task automatic run_move(input logic [POS_W-1:0] steps, input logic dir, input int period,
                            input int abort_mode, input string tag);
        int n, rises, width, last_rise, last_fall, first_rise, done_at, exp_pulses, gap_exp;
        bit in_pulse, fin;
        n = 0; rises = 0; width = 0; last_rise = 0; last_fall = 0; first_rise = 0;
        done_at = 0; in_pulse = 0; fin = 0;
        rate_period = period;
        repeat (period + $urandom_range(0, period)) @(negedge clk);
        chk({tag, "_ready"}, cmd_ready, 1);
        cmd_steps = steps;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_steps = $urandom;
        cmd_dir   = 1'($urandom);
        n = 1;
        if (steps != 0) dir_model = dir;
        chk({tag, "_dir_early"}, dir_out, dir_model);
        chk({tag, "_ovr_clr"}, rate_overrun, 0);
        chk({tag, "_busy"}, busy, 1);

        exp_pulses = (abort_mode == -1) ? 0 : (abort_mode > 0) ? abort_mode : int'(steps);
        gap_exp    = period * ((SH + 1 + period - 1) / period);

        while (!fin && n < 3000) begin
            abort = 1'b0;
            if (step_out && !in_pulse) begin
                rises++;
                if (rises == 1) first_rise = n;
                else chk({tag, "_gap"}, n - last_rise, gap_exp);
                last_rise = n;
                width     = 1;
                in_pulse  = 1;
            end else if (step_out) begin
                width++;
            end else if (in_pulse) begin
                in_pulse  = 0;
                last_fall = n;
                chk({tag, "_width"}, width, SH);
            end
            if (done && done_at == 0) done_at = n;
            if (done_at > 0 && n > done_at) fin = 1;
            if (abort_mode == -1 && n == 1) abort = 1'b1;
            if (abort_mode > 0 && rises == abort_mode && in_pulse && width == 3) abort = 1'b1;
            if (!fin) begin
                @(negedge clk);
                n++;
            end
        end
        abort = 1'b0;
        if (!fin) chk({tag, "_timeout"}, 0, 1);

        if (dir_model) pos_model = pos_model + POS_W'(exp_pulses);
        else           pos_model = pos_model - POS_W'(exp_pulses);

        chk({tag, "_pulses"}, rises, exp_pulses);
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_ready_after"}, cmd_ready, 1);
        if (exp_pulses > 0) begin
            chk({tag, "_done_at_fall"}, done_at, last_fall);
            chk({tag, "_setup_time"}, first_rise >= DS + 1, 1);
        end
        if (steps == 0) chk({tag, "_done_at"}, done_at, 1);
        chk({tag, "_position"}, position, pos_model);
        chk({tag, "_remaining"}, steps_remaining, steps - POS_W'(exp_pulses));
        chk({tag, "_overrun"}, rate_overrun, (exp_pulses > 0) && (period < SH + 1));
        chk({tag, "_dir"}, dir_out, dir_model);
    endtask

    initial begin
        int periods[6] = '{4, 6, 7, 9, 13, 20};
        int k;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step", step_out, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_done", done, 0);
        chk("rst_pos", position, 0);
        chk("rst_rem", steps_remaining, 0);
        chk("rst_ovr", rate_overrun, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        resetb = 1'b1;

        run_move(3, 1'b1, 40, 0, "basic3");
        run_move(5, 1'b0, 40, 0, "neg5");
        chk("neg5_allones", position, 32'hFFFF_FFFE);
        run_move(10, 1'b1, 40, 4, "abort4");
        run_move(4, 1'b0, 6, 0, "overrun");
        run_move(0, 1'b1, 40, 0, "zero");
        run_move(3, 1'b1, 20, -1, "abort_setup");

        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(0, 5));
            run_move(POS_W'($urandom_range(1, 5)), 1'($urandom), periods[k], 0, "rand");
        end

        // asynchronous reset in the middle of a pulse
        rate_period = 20;
        repeat (25) @(negedge clk);
        cmd_steps = 5; cmd_dir = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!step_out && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reached", step_out, 1);
        #2 resetb = 1'b0;
        #1;
        chk("rst_mid_step", step_out, 0);
        chk("rst_mid_pos", position, 0);
        chk("rst_mid_busy", busy, 0);
        pos_model = '0;
        dir_model = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_nodone", done, 0);
        end
        resetb = 1'b1;

        run_move(1, 1'b0, 20, 0, "to_max");
        chk("to_max_allones", position, 32'hFFFF_FFFF);
        run_move(1, 1'b1, 20, 0, "wrap");
        chk("wrap_zero", position, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stepper_move_controller.md
STEPPER_MOVE_CONTROLLER -- requirements
Module: stepper_move_controller

Interface
REQ-001 Parameter POS_W, default 32: width of step count, position and remaining-step fields.
REQ-002 Parameter DIR_SETUP_CYCLES, default 4 (>=1): clk cycles dir_out is stable before the first step pulse.
REQ-003 Parameter STEP_HIGH_CYCLES, default 8 (>=1): clk cycles step_out is held high per step.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 rate_in  input  1  step-rate square wave from pulse_generator_module; each rising edge requests one step.
REQ-007 cmd_valid  input  1  move command offered.
REQ-008 cmd_ready  output  1  controller can accept a command.
REQ-009 cmd_steps  input  POS_W  unsigned number of steps to issue.
REQ-010 cmd_dir  input  1  direction; 1 = positive, 0 = negative.
REQ-011 abort  input  1  stop the current move at the next step boundary.
REQ-012 step_out  output  1  STEP pin to driver.
REQ-013 dir_out  output  1  DIR pin to driver.
REQ-014 busy  output  1  move in progress (state not IDLE).
REQ-015 done  output  1  one-cycle pulse at end of every accepted move, normal or aborted.
REQ-016 position  output  POS_W  signed two's-complement absolute step position.
REQ-017 steps_remaining  output  POS_W  steps still to issue in the current or last move.
REQ-018 rate_overrun  output  1  sticky: a rate_in rising edge arrived while a step pulse was high.

Function
REQ-019 Rate edge detect: rate_prev register; rise = rate_in & ~rate_prev, evaluated every cycle.
REQ-020 States: IDLE, SETUP, RUN, HIGH, DONE; all outputs registered except cmd_ready and busy, which decode state.
REQ-021 cmd_ready = 1 only in IDLE; a handshake is cmd_valid & cmd_ready at a rising edge; cmd_valid outside IDLE is ignored.
REQ-022 On handshake with cmd_steps != 0: dir_out <= cmd_dir, steps_remaining <= cmd_steps, rate_overrun <= 0, setup counter loaded, state -> SETUP.
REQ-023 On handshake with cmd_steps == 0: dir_out, position unchanged; steps_remaining <= 0; rate_overrun <= 0; state -> DONE.
REQ-024 SETUP lasts exactly DIR_SETUP_CYCLES cycles, then RUN; rate edges during SETUP are discarded without setting rate_overrun.
REQ-025 RUN, rise = 1, abort = 0: next edge step_out <= 1, steps_remaining decrements by 1, position += 1 if dir_out = 1 else -= 1, state -> HIGH.
REQ-026 HIGH lasts exactly STEP_HIGH_CYCLES cycles with step_out = 1; then step_out <= 0 and state -> DONE if steps_remaining == 0 or abort is pending, else RUN.
REQ-027 rise during HIGH: step is dropped, rate_overrun <= 1; no queuing.
REQ-028 abort in SETUP or RUN: state -> DONE next edge; no step issued, even if rise in the same cycle (abort wins).
REQ-029 abort in HIGH: latched as pending; pulse completes its full width; pending cleared on entry to IDLE.
REQ-030 abort in IDLE or DONE: ignored.
REQ-031 DONE lasts one cycle with done = 1, then IDLE; steps_remaining holds its value (nonzero after an abort).
REQ-032 position wraps modulo 2^POS_W; steps_remaining never decrements below 0.
REQ-033 Minimum step period: one step per STEP_HIGH_CYCLES+1 cycles; faster rate_in edges set rate_overrun.

Reset
REQ-034 resetb low, asynchronously: state IDLE, step_out 0, dir_out 0, done 0, position 0, steps_remaining 0, rate_overrun 0, rate_prev 0, abort pending 0.
REQ-035 Reset mid-move terminates immediately: step_out drops to 0 without completing the pulse; no done pulse.
REQ-036 rate_in high at reset release is treated as a rise in the first cycle (discarded if IDLE).

Verification
REQ-037 Defaults; cmd_steps = 3, cmd_dir = 1, rate_in period 40 cycles -> dir_out = 1 before first step, 3 step_out pulses each 8 cycles high, first one >= 4 cycles after dir_out change, position 3, steps_remaining 0, one done pulse, cmd_ready back to 1.
REQ-038 From position 3: cmd_steps = 5, cmd_dir = 0 -> position -2 (all ones at POS_W = 32), 5 pulses, dir_out = 0.
REQ-039 cmd_steps = 10, abort asserted during the 4th pulse's high time -> 4th pulse full 8 cycles, no 5th, done one cycle later, steps_remaining 6.
REQ-040 rate_in period 6 cycles (< 9) with cmd_steps = 4 -> every other edge dropped, rate_overrun = 1, still exactly 4 pulses; cleared on next handshake.
REQ-041 cmd_steps = 0 -> done pulse the cycle after handshake, no step_out activity, dir_out and position unchanged.
REQ-042 resetb low during a step pulse -> step_out 0 immediately, position 0, no done; position at 2^32-1 plus one positive step -> 0.
